lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit sitting downstream of the ALU: consumes the effective address on o_aluData
//  (base+offset, aluOp ADD) plus store data/size from decode, and runs one handshaked memory
//  transaction per request. Builds byte enables and shifted store data; extracts and sign/zero-
//  extends load data; flags misaligned accesses and memory timeouts. One outstanding request.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles in ACCESS without i_mem_ack before error response (1..255)
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset        in   1   asynchronous, active-high reset
//  i_req_valid    in   1   request present (held with fields stable until accepted)
//  o_req_ready    out  1   LSU can accept; transfer when i_req_valid & o_req_ready
//  i_addr         in   32  effective byte address (ALU result)
//  i_wdata        in   32  store data, LSB-aligned (rs2)
//  i_we           in   1   1=store, 0=load
//  i_size         in   2   00=byte 01=half 10=word 11=illegal(treated misaligned)
//  i_unsigned     in   1   load zero-extend (LBU/LHU) when 1, sign-extend when 0
//  o_mem_req      out  1   memory request, held high until i_mem_ack
//  o_mem_addr     out  32  word address {i_addr[31:2],2'b00}
//  o_mem_we       out  1   write strobe
//  o_mem_be       out  4   byte enables
//  o_mem_wdata    out  32  store data replicated/shifted to lane
//  i_mem_ack      in   1   memory completes access this cycle
//  i_mem_rdata    in   32  read word, valid when i_mem_ack & ~o_mem_we
//  o_rsp_valid    out  1   one-cycle pulse: response ready
//  o_rsp_rdata    out  32  extended load data (0 for stores/errors)
//  o_rsp_err      out  2   00 ok, 01 misaligned, 10 timeout
// BEHAVIOUR
//  Reset: state IDLE; o_req_ready=1; o_mem_req=0, o_mem_we=0, o_mem_be=0, o_mem_addr=0,
//   o_mem_wdata=0; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0; timeout counter=0. Reset mid-
//   transaction aborts immediately; no response is ever produced for the aborted request.
//  FSM IDLE -> ACCESS on accepted aligned request; IDLE -> RESP on accepted misaligned request
//   (half with addr[0]=1, word with addr[1:0]!=0, size 11); no memory request issued.
//  ACCESS: o_mem_req=1, fields registered at accept and held stable. i_mem_ack -> RESP (err 00).
//   Counter increments each ACCESS cycle without ack; reaching TIMEOUT_CYC -> RESP (err 10),
//   o_mem_req drops; ack arriving same cycle as timeout wins (err 00).
//  RESP: o_rsp_valid=1 exactly one cycle, then IDLE. o_req_ready=1 only in IDLE.
//  Latency: accept edge -> mem_req next cycle; ack edge -> rsp_valid next cycle. Min 3 cycles
//   accept-to-response with zero-wait memory; misaligned 2 cycles.
//  Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0] (a[1:0] in {0,2}); word 1111.
//  Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//  Load extract: byte lane a[1:0], half lane a[1]; extend per i_unsigned to 32 bits; word as-is.
//   Read data latched on the ack cycle; i_mem_rdata ignored on stores.
//  i_req_valid while not ready: ignored, requester must hold.
// TESTING
//  LW a=0x100, mem ack 1 cycle later rdata=0xDEADBEEF -> rsp rdata=0xDEADBEEF err=00, be=1111
//  LB a=0x103 rdata=0x80112233 -> rdata=0xFFFFFF80; LBU same -> 0x00000080; be=1000
//  SH a=0x202 wdata=0x0000ABCD -> mem_addr=0x200 be=1100 wdata=0xABCDABCD we=1, rsp rdata=0
//  LW a=0x101 -> no o_mem_req ever, rsp 2 cycles after accept, err=01
//  LW with ack never asserted, TIMEOUT_CYC=8 -> mem_req high 8 cycles, rsp err=10, ready back
//  Assert i_reset during ACCESS -> all outputs reset next eval, no rsp pulse, next req works

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit memory controller.
// Accepts one request at a time from the ALU/decode stage, runs a single
// handshaked memory access, and returns a one-cycle response carrying the
// extended load data and an error code (misaligned or timeout).
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        misaligned;
  logic        tmo_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Handshake and memory-request strobes are pure functions of the state.
  assign o_req_ready = (state == IDLE);
  assign o_mem_req   = (state == ACCESS);
  assign o_rsp_valid = (state == RESP);

  // Last waiting cycle before the timeout fires; an ack in this cycle still wins.
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYC - 1));

  // Alignment check on the incoming request; size 11 is never legal.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    unique case (i_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_addr[0];
      2'b10:   misaligned = (i_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Next-state logic for the request/access/response sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_req_valid) state_nxt = misaligned ? RESP : ACCESS;
      ACCESS:  if (i_mem_ack || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Store lane steering: byte enables and replicated store data.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = i_wdata;
    unique case (i_size)
      2'b00: begin
        be_nxt    = 4'b0001 << i_addr[1:0];
        wdata_nxt = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << i_addr[1:0];
        wdata_nxt = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the registered request.
  always_comb begin
    unique case (lane_q)
      2'd0:    byte_sel = i_mem_rdata[7:0];
      2'd1:    byte_sel = i_mem_rdata[15:8];
      2'd2:    byte_sel = i_mem_rdata[23:16];
      default: byte_sel = i_mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = i_mem_rdata;
    endcase
  end

  // Request capture, timeout counting and response formation.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt     <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= ERR_OK;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req_valid) begin
            tmo_cnt     <= '0;
            o_rsp_rdata <= '0;
            if (misaligned) begin
              o_rsp_err <= ERR_MISALGN;
            end else begin
              o_rsp_err   <= ERR_OK;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_we    <= i_we;
              o_mem_be    <= be_nxt;
              o_mem_wdata <= wdata_nxt;
              lane_q      <= i_addr[1:0];
              size_q      <= i_size;
              uns_q       <= i_unsigned;
            end
          end
        end
        ACCESS: begin
          if (i_mem_ack) begin
            o_rsp_err   <= ERR_OK;
            o_rsp_rdata <= o_mem_we ? 32'd0 : load_ext;
          end else if (tmo_hit) begin
            o_rsp_err   <= ERR_TIMEOUT;
            o_rsp_rdata <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
